// File: rtl/vme_regslave.sv
// VME A16 register-window slave with an explicit DTACK FSM for the wfd125 control CPLD.
// Define VMESLV_GA_DECODE_EN to decode by geographical address (slot) instead of BASE.
module vme_regslave #(
    parameter int unsigned DW     = 8,
    parameter logic [15:0] BASE   = 16'h0179,
    parameter int unsigned NRL    = 4,
    parameter logic [5:0]  AM0    = 6'h2D,
    parameter logic [5:0]  AM1    = 6'h29,
    parameter int unsigned RD_LAT = 1,
    parameter logic [7:0]  TMO    = 8'd255
) (
    input  logic           CPLDCLK,
    input  logic           CRST,
    input  logic [15:0]    XA,
    input  logic [5:0]     XAM,
    input  logic [5:0]     XGA,
    input  logic           XAS,
    input  logic [1:0]     XDS,
    input  logic           XWRITE,
    input  logic           XIACK,
    inout  wire  [DW-1:0]  XD,
    output logic           XDTACK,
    output logic           XDTACKOE,
    output wire            DDIR,
    output logic [NRL-1:0] REG_ADDR,
    output logic [DW-1:0]  REG_WDATA,
    output logic           REG_WE,
    output logic           REG_RE,
    input  logic [DW-1:0]  REG_RDATA,
    output logic           BUSY
);

    typedef enum logic [2:0] {StIdle, StStrb, StWait, StAck, StRel} state_e;

    state_e         state_q, state_d;
    logic [1:0]     as_sync_q, wr_sync_q, ds_meta_q, ds_sync_q;
    logic           rearm_q, rearm_d;
    logic           is_rd_q, is_rd_d;
    logic [1:0]     wait_q, wait_d;
    logic [7:0]     tmo_q, tmo_d;
    logic [NRL-1:0] addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;

    logic           as_s, wr_s, ds_active, ds_released, am_ok, addr_hit, decode, drive_rd;
    logic [NRL-1:0] reg_idx;

    // AS sync resets to "asserted" so strobes still held across a reset cannot re-trigger.
    always_ff @(posedge CPLDCLK) begin
        if (CRST) begin
            as_sync_q <= 2'b00;
            wr_sync_q <= 2'b11;
            ds_meta_q <= 2'b11;
            ds_sync_q <= 2'b11;
        end else begin
            as_sync_q <= {as_sync_q[0], XAS};
            wr_sync_q <= {wr_sync_q[0], XWRITE};
            ds_meta_q <= XDS;
            ds_sync_q <= ds_meta_q;
        end
    end

    assign as_s        = as_sync_q[1];
    assign wr_s        = wr_sync_q[1];
    assign ds_active   = (DW == 16) ? (ds_sync_q == 2'b00) : !ds_sync_q[0];
    assign ds_released = (DW == 16) ? (ds_sync_q == 2'b11) : ds_sync_q[0];
    assign am_ok       = (XAM == AM0) || (XAM == AM1);
    assign reg_idx     = (DW == 16) ? XA[NRL:1] : XA[NRL-1:0];

`ifdef VMESLV_GA_DECODE_EN
    logic unused_xa;
    assign unused_xa = ^XA;
    // Odd parity over GA[4:0] and GAP; a parity error blocks every decode.
    assign addr_hit  = (XA[15:11] == ~XGA[4:0]) && (^XGA);
`else
    logic unused_ga;
    assign unused_ga = ^XGA;
    assign addr_hit  = (XA[15:NRL] == BASE[15-NRL:0]);
`endif

    assign decode = rearm_q && !as_s && XIACK && am_ok && addr_hit && ds_active;

    always_comb begin
        state_d = state_q;
        rearm_d = rearm_q;
        is_rd_d = is_rd_q;
        wait_d  = wait_q;
        tmo_d   = '0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (as_s) rearm_d = 1'b1;
                if (decode) begin
                    state_d = StStrb;
                    rearm_d = 1'b0;
                    is_rd_d = wr_s;
                    addr_d  = reg_idx;
                    if (!wr_s) wdata_d = XD;
                end
            end
            StStrb: begin
                wait_d = '0;
                if (is_rd_q && RD_LAT == 0) rdata_d = REG_RDATA;
                if (as_s) state_d = StIdle;
                else if (is_rd_q && RD_LAT != 0) state_d = StWait;
                else state_d = StAck;
            end
            StWait: begin
                wait_d = wait_q + 2'd1;
                if (as_s) begin
                    state_d = StIdle;
                end else if (wait_q == 2'(RD_LAT - 1)) begin
                    rdata_d = REG_RDATA;
                    state_d = StAck;
                end
            end
            StAck: begin
                tmo_d = tmo_q + 8'd1;
                if (ds_released || tmo_d == TMO) state_d = StRel;
            end
            StRel:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CPLDCLK) begin
        if (CRST) begin
            state_q <= StIdle;
            rearm_q <= 1'b0;
            is_rd_q <= 1'b0;
            wait_q  <= '0;
            tmo_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rearm_q <= rearm_d;
            is_rd_q <= is_rd_d;
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign drive_rd = is_rd_q && (state_q == StAck || state_q == StRel);
    assign XD       = drive_rd ? rdata_q : {DW{1'bz}};
    assign DDIR     = drive_rd ? 1'b1 : 1'bz;

    always_comb begin
        XDTACK    = (state_q != StAck);
        XDTACKOE  = !(state_q == StAck || state_q == StRel);
        REG_WE    = (state_q == StStrb) && !is_rd_q;
        REG_RE    = (state_q == StStrb) && is_rd_q;
        REG_ADDR  = addr_q;
        REG_WDATA = wdata_q;
        BUSY      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_vme_regslave.sv
// Self-checking bench for vme_regslave: directed cases plus randomized cycles against a
// transaction-level model (which cycles are acknowledged, which strobe, what data).
module tb_vme_regslave;

    localparam int unsigned DW     = 8;
    localparam int unsigned NRL    = 4;
    localparam int unsigned RD_LAT = 2;
    localparam logic [7:0]  TMO    = 8'd16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] xa = '0;
    logic [5:0]  xam = '0;
    logic [5:0]  xga = 6'b111110;
    logic        xas = 1'b1;
    logic [1:0]  xds = 2'b11;
    logic        xwrite = 1'b1;
    logic        xiack = 1'b1;
    logic [7:0]  tb_xd = '0;
    logic        tb_xd_en = 1'b0;
    wire  [7:0]  xd;
    wire         ddir;
    logic        xdtack, xdtackoe, reg_we, reg_re, busy;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_wdata, reg_rdata;

    logic [7:0]  rf [16];
    logic        re_d1 = 1'b0, re_d2 = 1'b0;
    logic [3:0]  ra_d1 = '0, ra_d2 = '0;

    int          we_cnt = 0, re_cnt = 0, both_cnt = 0, oe_cnt = 0;
    logic [3:0]  we_addr = '0, re_addr = '0;
    logic [7:0]  we_data = '0;
    int          n_chk = 0, n_pass = 0, n_fail = 0;

    always #5 clk = ~clk;

    assign xd = tb_xd_en ? tb_xd : 8'hzz;

    vme_regslave #(
        .DW     (DW),
        .NRL    (NRL),
        .RD_LAT (RD_LAT),
        .TMO    (TMO)
    ) dut (
        .CPLDCLK   (clk),
        .CRST      (rst),
        .XA        (xa),
        .XAM       (xam),
        .XGA       (xga),
        .XAS       (xas),
        .XDS       (xds),
        .XWRITE    (xwrite),
        .XIACK     (xiack),
        .XD        (xd),
        .XDTACK    (xdtack),
        .XDTACKOE  (xdtackoe),
        .DDIR      (ddir),
        .REG_ADDR  (reg_addr),
        .REG_WDATA (reg_wdata),
        .REG_WE    (reg_we),
        .REG_RE    (reg_re),
        .REG_RDATA (reg_rdata),
        .BUSY      (busy)
    );

    // Register file: data is only correct exactly RD_LAT cycles after REG_RE, inverted otherwise.
    always @(posedge clk) begin
        re_d1 <= reg_re;
        re_d2 <= re_d1;
        ra_d1 <= reg_addr;
        ra_d2 <= ra_d1;
    end
    assign reg_rdata = re_d2 ? rf[ra_d2] : ~rf[ra_d2];

    always @(negedge clk) begin
        if (reg_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= reg_addr;
            we_data <= reg_wdata;
        end
        if (reg_re) begin
            re_cnt  <= re_cnt + 1;
            re_addr <= reg_addr;
        end
        if (reg_we && reg_re) both_cnt <= both_cnt + 1;
        if (!xdtackoe) oe_cnt <= oe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] hit_addr(input logic [3:0] idx);
`ifdef VMESLV_GA_DECODE_EN
        return {5'b00001, 7'h00, idx};
`else
        return {12'h179, idx};
`endif
    endfunction

    function automatic logic exp_resp(input logic [15:0] a, input logic [5:0] am,
                                      input logic iack_n, input logic [5:0] ga);
        logic hit;
`ifdef VMESLV_GA_DECODE_EN
        hit = (a[15:11] == ~ga[4:0]) && ((ga[0] + ga[1] + ga[2] + ga[3] + ga[4] + ga[5]) % 2 == 1);
`else
        hit = (a[15:4] == 12'h179) && (ga == ga);
`endif
        return iack_n && (am == 6'h2D || am == 6'h29) && hit;
    endfunction

    task automatic release_bus();
        xds = 2'b11;
        repeat (3) @(negedge clk);
        xas      = 1'b1;
        tb_xd_en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic vme_cycle(input logic [15:0] a, input logic [5:0] am, input logic iack_n,
                             input logic wr, input logic [7:0] d, input logic hold_ds,
                             output logic acked, output int lat, output logic [7:0] rd,
                             output logic dd);
        @(negedge clk);
        xa = a; xam = am; xiack = iack_n; xwrite = ~wr; tb_xd = d; tb_xd_en = wr;
        @(negedge clk);
        xas = 1'b0;
        @(negedge clk);
        xds = 2'b00;
        acked = 1'b0; lat = 0; rd = '0; dd = 1'b0;
        for (int i = 1; i <= 12 && !acked; i++) begin
            @(negedge clk);
            if (!xdtack) begin
                acked = 1'b1; lat = i; rd = xd; dd = ddir;
            end
        end
        if (!hold_ds) release_bus();
        xiack = 1'b1;
    endtask

    task automatic run_and_check(input logic [15:0] a, input logic [5:0] am,
                                 input logic iack_n, input logic wr, input logic [7:0] d);
        int we0, re0, oe0, lat;
        logic exp, acked, dd;
        logic [7:0] rd;
        we0 = we_cnt; re0 = re_cnt; oe0 = oe_cnt;
        exp = exp_resp(a, am, iack_n, xga);
        vme_cycle(a, am, iack_n, wr, d, 1'b0, acked, lat, rd, dd);
        check("acked", 32'(acked), 32'(exp));
        check("we_pulses", we_cnt - we0, (exp && wr) ? 1 : 0);
        check("re_pulses", re_cnt - re0, (exp && !wr) ? 1 : 0);
        if (exp) begin
            check("dtack_latency_le6", 32'(lat <= 6), 1);
            check("dtack_released", 32'(xdtack), 1);
            if (wr) begin
                check("we_addr", 32'(we_addr), 32'(a[3:0]));
                check("we_data", 32'(we_data), 32'(d));
            end else begin
                check("re_addr", 32'(re_addr), 32'(a[3:0]));
                check("read_xd", 32'(rd), 32'(rf[a[3:0]]));
                check("read_ddir", 32'(dd), 1);
            end
        end else begin
            check("oe_never_low", oe_cnt - oe0, 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0, re0, lat, lowcnt;
        logic acked, dd;
        logic [7:0] rd;
        logic [15:0] a;
        logic [5:0] am;
        for (int i = 0; i < 16; i++) rf[i] = 8'($urandom);
        rf[15] = 8'h3C;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dtack", 32'(xdtack), 1);
        check("rst_dtackoe", 32'(xdtackoe), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_we_re", 32'({reg_we, reg_re}), 0);
        check("rst_addr", 32'(reg_addr), 0);
        check("rst_wdata", 32'(reg_wdata), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Directed write and read
        run_and_check(hit_addr(4'h3), 6'h2D, 1'b1, 1'b1, 8'hA5);
        run_and_check(hit_addr(4'hF), 6'h29, 1'b1, 1'b0, 8'h00);

        // DS held after DTACK: forced release after TMO cycles, no second strobe
        we0 = we_cnt; re0 = re_cnt;
        vme_cycle(hit_addr(4'h7), 6'h2D, 1'b1, 1'b1, 8'h5E, 1'b1, acked, lat, rd, dd);
        check("tmo_acked", 32'(acked), 1);
        lowcnt = acked ? 1 : 0;
        for (int i = 0; i < 40 && !xdtack; i++) begin
            @(negedge clk);
            if (!xdtack) lowcnt++;
        end
        check("tmo_ack_cycles", lowcnt, 32'(TMO));
        repeat (10) @(negedge clk);
        check("tmo_single_strobe", (we_cnt - we0) + (re_cnt - re0), 1);
        check("tmo_oe_released", 32'(xdtackoe), 1);
        check("tmo_idle", 32'(busy), 0);
        release_bus();

        // Non-decoded cycles
        run_and_check(16'h1800, 6'h2D, 1'b1, 1'b1, 8'h11);
        run_and_check(hit_addr(4'h2), 6'h3D, 1'b1, 1'b1, 8'h22);
        run_and_check(hit_addr(4'h2), 6'h2D, 1'b0, 1'b0, 8'h33);

        // Reset while in ACK drops the cycle at once
        vme_cycle(hit_addr(4'hF), 6'h29, 1'b1, 1'b0, 8'h00, 1'b1, acked, lat, rd, dd);
        we0 = we_cnt; re0 = re_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("crst_dtack", 32'(xdtack), 1);
        check("crst_dtackoe", 32'(xdtackoe), 1);
        check("crst_busy", 32'(busy), 0);
        rst = 1'b0;
        release_bus();
        check("crst_no_retrigger", (we_cnt - we0) + (re_cnt - re0), 0);
        run_and_check(hit_addr(4'h9), 6'h2D, 1'b1, 1'b1, 8'hC3);

`ifdef VMESLV_GA_DECODE_EN
        xga = 6'b111110;
        run_and_check(16'h0805, 6'h2D, 1'b1, 1'b1, 8'h77);
        xga = 6'b011110;
        run_and_check(16'h0805, 6'h2D, 1'b1, 1'b1, 8'h78);
        xga = 6'b111110;
`endif

        // Randomized cycles
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 3) != 0) ? hit_addr(4'($urandom_range(0, 15))) : 16'($urandom);
            case ($urandom_range(0, 4))
                0, 1:    am = 6'h2D;
                2:       am = 6'h29;
                3:       am = 6'h3D;
                default: am = 6'($urandom);
            endcase
            run_and_check(a, am, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                          8'($urandom));
        end

        check("never_both_strobes", both_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
